// File: rtl/edulent_pkg.sv
// Shared EduLent encodings: transfer commands, SP ops and the CALL opcode.
// Used by both the control unit and the transfer datapath.
package edulent_pkg;

  localparam int unsigned CMD_W   = 4;
  localparam int unsigned SP_OP_W = 2;
  localparam int unsigned OPC_W   = 8;

  localparam logic [OPC_W-1:0] OPC_CALL = 8'hC1;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE    = 4'h0,
    CMD_MA_PC   = 4'h1,
    CMD_MD_MEM  = 4'h2,
    CMD_IR_MD   = 4'h3,
    CMD_MA_MD   = 4'h4,
    CMD_ACC_MD  = 4'h5,
    CMD_MA_AP   = 4'h6,
    CMD_MA_SP   = 4'h7,
    CMD_MD_ACC  = 4'h8,
    CMD_MEM_WR  = 4'h9,
    CMD_ACC_ALU = 4'hA,
    CMD_PC_MD   = 4'hB,
    CMD_A_IN    = 4'hC,
    CMD_OUT_A   = 4'hD,
    CMD_PC_AP   = 4'hE,
    CMD_MD_PC   = 4'hF
  } transfer_cmd_t;

  typedef enum logic [SP_OP_W-1:0] {
    SP_HOLD     = 2'b00,
    SP_INC      = 2'b01,
    SP_DEC      = 2'b10,
    SP_HOLD_ALT = 2'b11
  } sp_op_t;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with modulo inc/dec.
// STACK_GUARD_EN adds a sticky fault flag on wrap; otherwise the flag is tied low.
module stack_pointer
  import edulent_pkg::*;
#(
  parameter int unsigned          DATA_W   = 8,
  parameter logic [DATA_W-1:0]    SP_RESET = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sp_op,
  output logic [DATA_W-1:0] sp,
  output logic              stack_fault
);

  sp_op_t op;
  assign op = sp_op_t'(sp_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= SP_RESET;
    end else begin
      case (op)
        SP_INC:  sp <= sp + DATA_W'(1);
        SP_DEC:  sp <= sp - DATA_W'(1);
        default: sp <= sp;
      endcase
    end
  end

`ifdef STACK_GUARD_EN
  // Wrap detected on the pre-update value; SP itself still wraps.
  logic wrap_c;
  assign wrap_c = ((op == SP_INC) && (sp == '1)) ||
                  ((op == SP_DEC) && (sp == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_fault <= 1'b0;
    end else if (wrap_c) begin
      stack_fault <= 1'b1;
    end
  end
`else
  assign stack_fault = 1'b0;
`endif

endmodule

// File: rtl/transfer_datapath.sv
// EduLent register-transfer datapath: PC, MA, MD, IR, A, AP, OUT plus SP sub-module.
// Optional SP wrap guard is enabled with the STACK_GUARD_EN macro.
module transfer_datapath
  import edulent_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter logic [DATA_W-1:0] SP_RESET = '1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_transfer_cmd,
  input  logic              i_inc_pc,
  input  logic [1:0]        i_inc_dec_sp,
  input  logic              i_alu_res_to_ap,
  input  logic              i_reset_ir,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [DATA_W-1:0] o_ir,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_ap,
  output logic [DATA_W-1:0] o_out,
  output logic              o_out_valid,
  output logic              o_stack_fault
);

  transfer_cmd_t cmd;
  assign cmd = transfer_cmd_t'(i_transfer_cmd);

  logic [DATA_W-1:0] pc, ma, md, ir, a, ap, out;
  logic              out_valid;
  logic [DATA_W-1:0] pc_nxt, ma_nxt, md_nxt, ir_nxt, a_nxt, ap_nxt, out_nxt;
  logic              out_valid_nxt;
  logic [DATA_W-1:0] sp;

  stack_pointer #(
    .DATA_W   (DATA_W),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk         (i_clk),
    .rst         (i_rst),
    .sp_op       (i_inc_dec_sp),
    .sp          (sp),
    .stack_fault (o_stack_fault)
  );

  // Memory transfers through MD target AP for stack-style opcodes and CALL.
  logic md_sel_ap_c;
  assign md_sel_ap_c = ir[1] | (ir == DATA_W'(OPC_CALL));

  // Write strobe is combinational so the RAM captures MD on the executing edge.
  assign o_mem_we = (cmd == CMD_MEM_WR) && !i_rst;

  always_comb begin
    pc_nxt        = i_inc_pc ? pc + DATA_W'(1) : pc;
    ma_nxt        = ma;
    md_nxt        = md;
    ir_nxt        = ir;
    a_nxt         = a;
    ap_nxt        = ap;
    out_nxt       = out;
    out_valid_nxt = 1'b0;

    case (cmd)
      CMD_MA_PC:  ma_nxt = pc;
      CMD_MD_MEM: md_nxt = i_mem_rdata;
      CMD_IR_MD:  ir_nxt = md;
      CMD_MA_MD:  ma_nxt = md;
      CMD_ACC_MD: begin
        if (md_sel_ap_c) ap_nxt = md;
        else             a_nxt  = md;
      end
      CMD_MA_AP:  ma_nxt = ap;
      CMD_MA_SP:  ma_nxt = sp;
      CMD_MD_ACC: md_nxt = md_sel_ap_c ? ap : a;
      CMD_ACC_ALU: begin
        if (i_alu_res_to_ap) ap_nxt = i_alu_result;
        else                 a_nxt  = i_alu_result;
      end
      CMD_PC_MD:  pc_nxt = md;
      CMD_A_IN:   a_nxt  = i_in;
      CMD_OUT_A: begin
        out_nxt       = a;
        out_valid_nxt = 1'b1;
      end
      CMD_PC_AP:  pc_nxt = ap;
      CMD_MD_PC:  md_nxt = pc;
      default: ;
    endcase

    // IR clear overrides a same-cycle load.
    if (i_reset_ir) ir_nxt = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc        <= PC_RESET;
      ma        <= '0;
      md        <= '0;
      ir        <= '0;
      a         <= '0;
      ap        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      ma        <= ma_nxt;
      md        <= md_nxt;
      ir        <= ir_nxt;
      a         <= a_nxt;
      ap        <= ap_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  assign o_mem_addr  = ma;
  assign o_mem_wdata = md;
  assign o_ir        = ir;
  assign o_a         = a;
  assign o_ap        = ap;
  assign o_out       = out;
  assign o_out_valid = out_valid;

endmodule

// File: tb/tb_transfer_datapath.sv
// Self-checking bench for transfer_datapath: directed test-plan scenarios followed
// by random command streams checked against a register-level reference model.
module tb_transfer_datapath;

  logic       clk;
  logic       rst;
  logic [3:0] transfer_cmd;
  logic       inc_pc;
  logic [1:0] inc_dec_sp;
  logic       alu_res_to_ap;
  logic       reset_ir;
  logic [7:0] alu_result;
  logic [7:0] in_port;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] ir;
  logic [7:0] a;
  logic [7:0] ap;
  logic [7:0] out;
  logic       out_valid;
  logic       stack_fault;

  transfer_datapath dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_transfer_cmd  (transfer_cmd),
    .i_inc_pc        (inc_pc),
    .i_inc_dec_sp    (inc_dec_sp),
    .i_alu_res_to_ap (alu_res_to_ap),
    .i_reset_ir      (reset_ir),
    .i_alu_result    (alu_result),
    .i_in            (in_port),
    .i_mem_rdata     (mem_rdata),
    .o_mem_addr      (mem_addr),
    .o_mem_we        (mem_we),
    .o_mem_wdata     (mem_wdata),
    .o_ir            (ir),
    .o_a             (a),
    .o_ap            (ap),
    .o_out           (out),
    .o_out_valid     (out_valid),
    .o_stack_fault   (stack_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read, synchronous-write data RAM.
  logic [7:0] mem [0:255];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference state, held as plain integers.
  int m_pc, m_sp, m_ma, m_md, m_ir, m_a, m_ap, m_out, m_ov, m_fault;
  int m_mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit md_targets_ap(input int ir_val);
    return (((ir_val / 2) % 2) == 1) || (ir_val == 'hC1);
  endfunction

  task automatic model_reset();
    m_pc = 0; m_sp = 255; m_ma = 0; m_md = 0; m_ir = 0;
    m_a = 0; m_ap = 0; m_out = 0; m_ov = 0; m_fault = 0;
  endtask

  task automatic model_step(input int cmd, input int inc, input int spop, input int to_ap,
                            input int clr_ir, input int r, input int inp);
    int n_pc = m_pc, n_sp = m_sp, n_ma = m_ma, n_md = m_md;
    int n_ir = m_ir, n_a = m_a, n_ap = m_ap, n_out = m_out;
    bit wrap = 0;
    if (inc != 0) n_pc = (m_pc + 1) % 256;
    case (cmd)
      1:  n_ma = m_pc;
      2:  n_md = m_mem[m_ma];
      3:  n_ir = m_md;
      4:  n_ma = m_md;
      5:  if (md_targets_ap(m_ir)) n_ap = m_md; else n_a = m_md;
      6:  n_ma = m_ap;
      7:  n_ma = m_sp;
      8:  n_md = md_targets_ap(m_ir) ? m_ap : m_a;
      9:  m_mem[m_ma] = m_md;
      10: if (to_ap != 0) n_ap = r; else n_a = r;
      11: n_pc = m_md;
      12: n_a = inp;
      13: n_out = m_a;
      14: n_pc = m_ap;
      15: n_md = m_pc;
      default: ;
    endcase
    if (spop == 1) begin n_sp = (m_sp + 1) % 256;   wrap = (m_sp == 255); end
    if (spop == 2) begin n_sp = (m_sp + 255) % 256; wrap = (m_sp == 0);   end
`ifdef STACK_GUARD_EN
    if (wrap) m_fault = 1;
`else
    if (wrap) m_fault = 0;
`endif
    if (clr_ir != 0) n_ir = 0;
    m_ov = (cmd == 13) ? 1 : 0;
    m_pc = n_pc; m_sp = n_sp; m_ma = n_ma; m_md = n_md;
    m_ir = n_ir; m_a = n_a; m_ap = n_ap; m_out = n_out;
  endtask

  task automatic check_all(input string where);
    check({where, ":ma"},    32'(mem_addr),        32'(m_ma));
    check({where, ":md"},    32'(mem_wdata),       32'(m_md));
    check({where, ":ir"},    32'(ir),              32'(m_ir));
    check({where, ":a"},     32'(a),               32'(m_a));
    check({where, ":ap"},    32'(ap),              32'(m_ap));
    check({where, ":out"},   32'(out),             32'(m_out));
    check({where, ":ov"},    32'(out_valid),       32'(m_ov));
    check({where, ":fault"}, 32'(stack_fault),     32'(m_fault));
    check({where, ":pc"},    32'(dut.pc),          32'(m_pc));
    check({where, ":sp"},    32'(dut.u_sp.sp),     32'(m_sp));
  endtask

  // One command cycle: drive, check the write strobe, clock, then check all state.
  task automatic cycle(input int cmd, input int inc, input int spop, input int to_ap,
                       input int clr_ir, input int r, input int inp, input string where);
    transfer_cmd  = 4'(cmd);
    inc_pc        = 1'(inc);
    inc_dec_sp    = 2'(spop);
    alu_res_to_ap = 1'(to_ap);
    reset_ir      = 1'(clr_ir);
    alu_result    = 8'(r);
    in_port       = 8'(inp);
    #2;
    check({where, ":we"}, 32'(mem_we), (cmd == 9) ? 32'd1 : 32'd0);
    if (cmd == 9) begin
      check({where, ":waddr"}, 32'(mem_addr),  32'(m_ma));
      check({where, ":wdata"}, 32'(mem_wdata), 32'(m_md));
    end
    @(posedge clk);
    model_step(cmd, inc, spop, to_ap, clr_ir, r, inp);
    #1;
    check_all(where);
  endtask

  task automatic poke(input int addr, input int val);
    mem[addr]   = 8'(val);
    m_mem[addr] = val;
  endtask

  initial begin
    int v;
    for (int i = 0; i < 256; i++) begin
      v = ($urandom_range(0, 7) == 0) ? 'hC1 : int'($urandom_range(0, 255));
      poke(i, v);
    end
    poke('h00, 'h19); poke('h01, 'h1B); poke('h1B, 'h5A);
    poke('h5A, 'h21); poke('h21, 'h40);

    rst = 1'b1; transfer_cmd = '0; inc_pc = 0; inc_dec_sp = '0;
    alu_res_to_ap = 0; reset_ir = 0; alu_result = '0; in_port = '0;
    model_reset();
    #1;
    check("rst_we", 32'(mem_we), 32'd0);
    check_all("rst");
    @(negedge clk); rst = 1'b0;

    // Instruction fetch
    cycle(1, 0, 0, 0, 0, 0, 0, "fetch_ma");
    cycle(2, 1, 0, 0, 0, 0, 0, "fetch_md");
    cycle(3, 0, 0, 0, 0, 0, 0, "fetch_ir");
    check("fetch_ma_val", 32'(mem_addr), 32'h00);
    check("fetch_md_val", 32'(mem_wdata), 32'h19);
    check("fetch_pc_val", 32'(dut.pc), 32'h01);
    check("fetch_ir_val", 32'(ir), 32'h19);

    // IR=1B, MD=5A, cmd 5 selects AP; then ALU result into A
    cycle(1, 0, 0, 0, 0, 0, 0, "sel_ma");
    cycle(2, 0, 0, 0, 0, 0, 0, "sel_md");
    cycle(3, 0, 0, 0, 0, 0, 0, "sel_ir");
    cycle(4, 0, 0, 0, 0, 0, 0, "sel_ma2");
    cycle(2, 0, 0, 0, 0, 0, 0, "sel_md2");
    cycle(5, 0, 0, 0, 0, 0, 0, "sel_ap");
    check("sel_ap_val", 32'(ap), 32'h5A);
    check("sel_a_keep", 32'(a), 32'h00);
    cycle(10, 0, 0, 0, 0, 'h33, 0, "alu_a");
    check("alu_a_val", 32'(a), 32'h33);

    // Memory write of A=7E to 40 with IR=21
    cycle(6, 0, 0, 0, 0, 0, 0, "wr_ma_ap");
    cycle(2, 0, 0, 0, 0, 0, 0, "wr_md");
    cycle(3, 0, 0, 0, 0, 0, 0, "wr_ir");
    cycle(4, 0, 0, 0, 0, 0, 0, "wr_ma");
    cycle(2, 0, 0, 0, 0, 0, 0, "wr_md2");
    cycle(4, 0, 0, 0, 0, 0, 0, "wr_ma2");
    cycle(12, 0, 0, 0, 0, 0, 'h7E, "wr_a_in");
    cycle(8, 0, 0, 0, 0, 0, 0, "wr_md_a");
    check("wr_addr_val", 32'(mem_addr), 32'h40);
    check("wr_data_val", 32'(mem_wdata), 32'h7E);
    cycle(9, 0, 0, 0, 0, 0, 0, "wr_exec");
    check("wr_mem_val", 32'(mem[8'h40]), 32'h7E);
    cycle(0, 0, 0, 0, 0, 0, 0, "wr_after");

    // Stack wrap both ways
    cycle(0, 0, 1, 0, 0, 0, 0, "sp_inc_wrap");
    check("sp_wrap_val", 32'(dut.u_sp.sp), 32'h00);
`ifdef STACK_GUARD_EN
    check("sp_fault_set", 32'(stack_fault), 32'd1);
`else
    check("sp_fault_tied", 32'(stack_fault), 32'd0);
`endif
    cycle(0, 0, 2, 0, 0, 0, 0, "sp_dec_wrap");
    check("sp_dec_val", 32'(dut.u_sp.sp), 32'hFF);
    cycle(7, 0, 2, 0, 0, 0, 0, "sp_ma_pre");
    check("sp_ma_pre_val", 32'(mem_addr), 32'hFF);

    // PC load beats increment
    cycle(12, 0, 0, 0, 0, 0, 'h20, "pcp_a");
    cycle(8, 0, 0, 0, 0, 0, 0, "pcp_md");
    cycle(11, 1, 0, 0, 0, 0, 0, "pcp_load");
    check("pcp_pc_val", 32'(dut.pc), 32'h20);

    // IR clear beats IR load
    cycle(3, 0, 0, 0, 1, 0, 0, "irclr");
    check("irclr_val", 32'(ir), 32'h00);

    // Reset during a write cycle after OUT was written
    cycle(13, 0, 0, 0, 0, 0, 0, "abort_out");
    transfer_cmd = 4'h9; inc_pc = 0; inc_dec_sp = '0; reset_ir = 0;
    #2;
    check("abort_we_pre", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_ov", 32'(out_valid), 32'd0);
    model_reset();
    check_all("abort");
    @(negedge clk);
    rst = 1'b0; transfer_cmd = '0;

    // Random command streams
    for (int n = 0; n < 400; n++) begin
      cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 1 : 0,
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
